mc_control: RTL
===============

Name: mc_control

Overview:
- Main controller FSM for the multi-cycle processor; the producing end of the ALU's 3-bit aluc interface.
- Sequences each instruction through fetch, decode, execute, memory and writeback cycles.
- Drives every datapath mux select, write enable and the aluc code.
- Consumes the ALU zero flag to resolve branches.

Parameters:
- OPW, 6, opcode field width.
- FNW, 6, funct field width.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- opcode  in  6  instr[31:26], valid from DECODE onward.
- funct  in  6  instr[5:0].
- zero  in  1  ALU zero flag, same cycle as the BRANCH subtract.
- iord  out  1  memory address select: 0=PC, 1=ALUOut.
- memwrite  out  1  data memory write enable.
- irwrite  out  1  instruction register load.
- regdst  out  1  write register select: 0=rt, 1=rd.
- memtoreg  out  1  writeback select: 0=ALUOut, 1=MDR.
- regwrite  out  1  register file write enable.
- alusrca  out  1  ALU A select: 0=PC, 1=A reg.
- alusrcb  out  2  ALU B select: 00=B, 01=4, 10=signimm, 11=signimm<<2.
- pcsrc  out  2  next-PC select: 00=ALU, 01=ALUOut, 10=jump target.
- pcen  out  1  PC write enable, including branch qualification.
- aluc  out  3  ALU control code.
- state  out  4  current FSM state, for debug.

Behaviour:
- Moore FSM. Outputs are decoded combinationally from the state register, except pcen, which also uses zero.
- Reset:
  - rst high at an edge forces state=FETCH (0).
  - While rst is high, memwrite, irwrite, regwrite and pcen are forced 0; all other outputs are 0.
  - Reset mid-instruction abandons that instruction; no partial write occurs after the reset edge.
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11, BNE=12. Codes 13-15 go to FETCH.
- FETCH:
  - Outputs: iord=0, irwrite=1, alusrca=0, alusrcb=01, aluc=010, pcsrc=00, pcen=1.
  - Next state: DECODE.
- DECODE:
  - Outputs: alusrca=0, alusrcb=11, aluc=010 (branch target into ALUOut).
  - Next state by opcode: 100011 or 101011 -> MEMADR; 000000 -> EXEC; 000100 -> BRANCH; 001000 -> ADDIEX; 000010 -> JUMP; any other opcode -> FETCH (treated as a NOP).
- MEMADR:
  - Outputs: alusrca=1, alusrcb=10, aluc=010.
  - Next state: lw -> MEMRD, sw -> MEMWR.
- MEMRD: iord=1 -> MEMWB.
- MEMWB: regdst=0, memtoreg=1, regwrite=1 -> FETCH.
- MEMWR: iord=1, memwrite=1 -> FETCH.
- EXEC:
  - Outputs: alusrca=1, alusrcb=00, aluc from funct.
  - funct decode: 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111, any other -> 011 (the result is still written back).
  - Next state: ALUWB.
- ALUWB: regdst=1, memtoreg=0, regwrite=1 -> FETCH.
- BRANCH:
  - Outputs: alusrca=1, alusrcb=00, aluc=110, pcsrc=01, pcen=zero.
  - Next state: FETCH.
- ADDIEX: alusrca=1, alusrcb=10, aluc=010 -> ADDIWB.
- ADDIWB: regdst=0, memtoreg=0, regwrite=1 -> FETCH.
- JUMP: pcsrc=10, pcen=1 -> FETCH.
- Latency in cycles, FETCH through the last state inclusive: R=4, lw=5, sw=4, beq=3, addi=4, j=3, undefined=2.
- Every output not listed for a state is 0.
- aluc is never 100 or 101.

Optional Feature:
- Macro: MC_CONTROL_BNE_EN.
- Defined:
  - In DECODE, opcode 000101 -> BNE.
  - BNE outputs match BRANCH except pcen=~zero; next state FETCH.
- Undefined:
  - The BNE state is absent.
  - Opcode 000101 is treated as undefined (DECODE -> FETCH).

Decomposition:
- Shared package mc_pkg holds:
  - state enum and codes;
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J;
  - funct constants;
  - aluc constants ALU_AND=000, ALU_OR=001, ALU_ADD=010, ALU_SUB=110, ALU_SLT=111;
  - alusrcb and pcsrc select constants.
- One sub-module, alu_dec: combinational map from (aluop[1:0], funct) to aluc.
  - aluop 00 -> add, 01 -> sub, 10 -> use funct.
  - mc_control generates aluop per state.

Test Plan:
- rst=1 for 2 cycles, then opcode=000000 -> at the first edge after release the state is DECODE; pcen, irwrite and regwrite were 0 throughout reset.
- lw (100011) -> states 0,1,2,3,4; MEMWB has regwrite=1, memtoreg=1; MEMADR has aluc=010, alusrcb=10.
- R-type funct=101010 -> EXEC has aluc=111; ALUWB has regdst=1, regwrite=1; total 4 cycles. Repeat for funct=100010 -> aluc=110.
- beq: zero=1 in BRANCH -> pcen=1, pcsrc=01; zero=0 -> pcen=0; both return to FETCH after 3 cycles.
- sw (101011) -> MEMWR has memwrite=1, iord=1, regwrite=0. j (000010) -> JUMP has pcsrc=10, pcen=1.
- Opcode 111111 -> DECODE then FETCH, with no write enable asserted. With MC_CONTROL_BNE_EN: opcode 000101, zero=0 -> pcen=1. Assert rst during MEMRD -> next state is FETCH and MEMWB never occurs.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle controller: state codes, opcode/funct
// constants, ALU codes and datapath select encodings. Honours MC_CONTROL_BNE_EN.
package mc_pkg;

  typedef enum logic [3:0] {
    ST_FETCH  = 4'd0,
    ST_DECODE = 4'd1,
    ST_MEMADR = 4'd2,
    ST_MEMRD  = 4'd3,
    ST_MEMWB  = 4'd4,
    ST_MEMWR  = 4'd5,
    ST_EXEC   = 4'd6,
    ST_ALUWB  = 4'd7,
    ST_BRANCH = 4'd8,
    ST_ADDIEX = 4'd9,
    ST_ADDIWB = 4'd10,
    ST_JUMP   = 4'd11
`ifdef MC_CONTROL_BNE_EN
    , ST_BNE  = 4'd12
`endif
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_UNDF = 3'b011;
  localparam logic [2:0] ALU_SUB  = 3'b110;
  localparam logic [2:0] ALU_SLT  = 3'b111;

  // aluop 11 marks states that do not use the ALU, so aluc idles at 000
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_IDLE  = 2'b11;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

endpackage

// File: rtl/alu_dec.sv
// ALU decoder: maps the controller's aluop and the instruction funct field
// onto the 3-bit aluc code.
module alu_dec
  import mc_pkg::*;
#(
  parameter int FNW = 6
) (
  input  logic [1:0]     aluop,
  input  logic [FNW-1:0] funct,
  output logic [2:0]     aluc
);

  always_comb begin
    aluc = ALU_AND;
    case (aluop)
      ALUOP_ADD: aluc = ALU_ADD;
      ALUOP_SUB: aluc = ALU_SUB;
      ALUOP_FUNCT: begin
        // unknown funct codes still produce a result that gets written back
        case (funct)
          FNW'(FN_ADD): aluc = ALU_ADD;
          FNW'(FN_SUB): aluc = ALU_SUB;
          FNW'(FN_AND): aluc = ALU_AND;
          FNW'(FN_OR):  aluc = ALU_OR;
          FNW'(FN_SLT): aluc = ALU_SLT;
          default:      aluc = ALU_UNDF;
        endcase
      end
      default: aluc = ALU_AND;
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// Multi-cycle processor main controller (Moore FSM, pcen also qualified by zero).
// Define MC_CONTROL_BNE_EN to add the BNE branch state.
module mc_control
  import mc_pkg::*;
#(
  parameter int OPW = 6,
  parameter int FNW = 6
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [OPW-1:0] opcode,
  input  logic [FNW-1:0] funct,
  input  logic           zero,
  output logic           iord,
  output logic           memwrite,
  output logic           irwrite,
  output logic           regdst,
  output logic           memtoreg,
  output logic           regwrite,
  output logic           alusrca,
  output logic [1:0]     alusrcb,
  output logic [1:0]     pcsrc,
  output logic           pcen,
  output logic [2:0]     aluc,
  output logic [3:0]     state
);

  state_t     state_q, state_d;
  logic       iord_c, memwrite_c, irwrite_c, regdst_c, memtoreg_c, regwrite_c;
  logic       alusrca_c, pcen_c;
  logic [1:0] alusrcb_c, pcsrc_c, aluop;
  logic [2:0] aluc_c;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = ST_FETCH;
    iord_c     = 1'b0;
    memwrite_c = 1'b0;
    irwrite_c  = 1'b0;
    regdst_c   = 1'b0;
    memtoreg_c = 1'b0;
    regwrite_c = 1'b0;
    alusrca_c  = 1'b0;
    alusrcb_c  = SRCB_B;
    pcsrc_c    = PC_ALU;
    pcen_c     = 1'b0;
    aluop      = ALUOP_IDLE;
    case (state_q)
      ST_FETCH: begin
        irwrite_c = 1'b1;
        alusrcb_c = SRCB_FOUR;
        aluop     = ALUOP_ADD;
        pcen_c    = 1'b1;
        state_d   = ST_DECODE;
      end
      ST_DECODE: begin
        alusrcb_c = SRCB_IMMSH;
        aluop     = ALUOP_ADD;
        case (opcode)
          OPW'(OP_LW), OPW'(OP_SW): state_d = ST_MEMADR;
          OPW'(OP_RTYPE):           state_d = ST_EXEC;
          OPW'(OP_BEQ):             state_d = ST_BRANCH;
          OPW'(OP_ADDI):            state_d = ST_ADDIEX;
          OPW'(OP_J):               state_d = ST_JUMP;
`ifdef MC_CONTROL_BNE_EN
          OPW'(OP_BNE):             state_d = ST_BNE;
`endif
          default:                  state_d = ST_FETCH;
        endcase
      end
      ST_MEMADR: begin
        alusrca_c = 1'b1;
        alusrcb_c = SRCB_IMM;
        aluop     = ALUOP_ADD;
        state_d   = (opcode == OPW'(OP_SW)) ? ST_MEMWR : ST_MEMRD;
      end
      ST_MEMRD: begin
        iord_c  = 1'b1;
        state_d = ST_MEMWB;
      end
      ST_MEMWB: begin
        memtoreg_c = 1'b1;
        regwrite_c = 1'b1;
      end
      ST_MEMWR: begin
        iord_c     = 1'b1;
        memwrite_c = 1'b1;
      end
      ST_EXEC: begin
        alusrca_c = 1'b1;
        aluop     = ALUOP_FUNCT;
        state_d   = ST_ALUWB;
      end
      ST_ALUWB: begin
        regdst_c   = 1'b1;
        regwrite_c = 1'b1;
      end
      ST_BRANCH: begin
        alusrca_c = 1'b1;
        aluop     = ALUOP_SUB;
        pcsrc_c   = PC_ALUOUT;
        pcen_c    = zero;
      end
`ifdef MC_CONTROL_BNE_EN
      ST_BNE: begin
        alusrca_c = 1'b1;
        aluop     = ALUOP_SUB;
        pcsrc_c   = PC_ALUOUT;
        pcen_c    = ~zero;
      end
`endif
      ST_ADDIEX: begin
        alusrca_c = 1'b1;
        alusrcb_c = SRCB_IMM;
        aluop     = ALUOP_ADD;
        state_d   = ST_ADDIWB;
      end
      ST_ADDIWB: regwrite_c = 1'b1;
      ST_JUMP: begin
        pcsrc_c = PC_JUMP;
        pcen_c  = 1'b1;
      end
      default: state_d = ST_FETCH;
    endcase
  end

  alu_dec #(.FNW(FNW)) u_alu_dec (
    .aluop (aluop),
    .funct (funct),
    .aluc  (aluc_c)
  );

  // reset holds every output low so an abandoned instruction cannot write
  assign iord     = rst ? 1'b0 : iord_c;
  assign memwrite = rst ? 1'b0 : memwrite_c;
  assign irwrite  = rst ? 1'b0 : irwrite_c;
  assign regdst   = rst ? 1'b0 : regdst_c;
  assign memtoreg = rst ? 1'b0 : memtoreg_c;
  assign regwrite = rst ? 1'b0 : regwrite_c;
  assign alusrca  = rst ? 1'b0 : alusrca_c;
  assign alusrcb  = rst ? 2'b00 : alusrcb_c;
  assign pcsrc    = rst ? 2'b00 : pcsrc_c;
  assign pcen     = rst ? 1'b0 : pcen_c;
  assign aluc     = rst ? 3'b000 : aluc_c;
  assign state    = rst ? 4'd0 : state_q;

endmodule
